// File: rtl/rpn_stack_core_if.sv
// Command/status bundle between the calculator front end and the RPN stack core.
// The front end drives the action pulses and operand; the core returns stack view and flags.
interface rpn_stack_core_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             enter_pulso;
  logic             exec_pulso;
  logic             clear_pulso;
  logic [WIDTH-1:0] data_in;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] tos;
  logic [CW-1:0]    depth;
  logic             busy;
  logic             result_valid;
  logic             carry;
  logic             zero;
  logic             error;

  modport master (
    output enter_pulso, exec_pulso, clear_pulso, data_in, sel_op,
    input  tos, depth, busy, result_valid, carry, zero, error
  );

  modport slave (
    input  enter_pulso, exec_pulso, clear_pulso, data_in, sel_op,
    output tos, depth, busy, result_valid, carry, zero, error
  );
endinterface

// File: rtl/rpn_stack_core.sv
// RPN calculator core: DEPTH x WIDTH operand stack, ALU and IDLE/EXEC/WRITE/ERR sequencer.
// An exec result lands on the stack on the EXEC->WRITE edge, so it is visible during WRITE.
module rpn_stack_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  rpn_stack_core_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE, ERR} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             carry_q, zero_q, err_q;

  logic [IW-1:0]    top_idx, sec_idx, push_idx;
  logic [WIDTH-1:0] opa, opb, alu_r;
  logic             alu_c;
  logic             full, underflow, unary_q;

  assign top_idx   = IW'(cnt - 1'b1);
  assign sec_idx   = IW'(cnt - 2'd2);
  assign push_idx  = IW'(cnt);
  assign opa       = stk[sec_idx];
  assign opb       = stk[top_idx];
  assign full      = (cnt == CW'(DEPTH));
  assign underflow = (bus.sel_op >= 3'd5) ? (cnt == '0) : (cnt < CW'(2));
  assign unary_q   = (op_q >= 3'd5);

  // The stack cannot change while busy, so operands are read live during EXEC.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (op_q)
      3'd0: {alu_c, alu_r} = {1'b0, opa} + {1'b0, opb};
      3'd1: begin alu_r = opa - opb; alu_c = (opa < opb); end
      3'd2: alu_r = opa & opb;
      3'd3: alu_r = opa | opb;
      3'd4: alu_r = opa ^ opb;
      3'd5: alu_r = ~opb;
      3'd6: begin alu_r = {opb[WIDTH-2:0], 1'b0}; alu_c = opb[WIDTH-1]; end
      default: begin alu_r = {1'b0, opb[WIDTH-1:1]}; alu_c = opb[0]; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.enter_pulso) begin
          if (full) state_nx = ERR;
        end else if (bus.exec_pulso) begin
          state_nx = underflow ? ERR : EXEC;
        end
      end
      EXEC:    state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
    if (bus.clear_pulso) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      cnt     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (bus.clear_pulso) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enter_pulso) begin
            if (full) err_q <= 1'b1;
            else begin
              stk[push_idx] <= bus.data_in;
              cnt           <= cnt + 1'b1;
            end
          end else if (bus.exec_pulso) begin
            if (underflow) err_q <= 1'b1;
            else           op_q  <= bus.sel_op;
          end
        end
        EXEC: begin
          if (unary_q) stk[top_idx] <= alu_r;
          else begin
            stk[sec_idx] <= alu_r;
            cnt          <= cnt - 1'b1;
          end
          carry_q <= alu_c;
          zero_q  <= (alu_r == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.tos          = (cnt == '0) ? '0 : stk[top_idx];
  assign bus.depth        = cnt;
  assign bus.busy         = (state == EXEC) || (state == WRITE);
  assign bus.result_valid = (state == WRITE);
  assign bus.carry        = carry_q;
  assign bus.zero         = zero_q;
  assign bus.error        = err_q;
endmodule

// File: tb/tb_rpn_stack_core.sv
// Drives an 8x4 and a 16x8 RPN core with one shared stimulus stream and checks both
// every cycle against a stack/countdown model, plus literal spot checks on known sequences.
module tb_rpn_stack_core;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enter, exec, clr;
  logic [2:0]  op;
  logic [15:0] din;

  int n_cmp = 0;
  int n_bad = 0;

  rpn_stack_core_if #(.WIDTH(8),  .DEPTH(4)) bus0 ();
  rpn_stack_core_if #(.WIDTH(16), .DEPTH(8)) bus1 ();

  assign bus0.enter_pulso = enter;
  assign bus0.exec_pulso  = exec;
  assign bus0.clear_pulso = clr;
  assign bus0.sel_op      = op;
  assign bus0.data_in     = din[7:0];
  assign bus1.enter_pulso = enter;
  assign bus1.exec_pulso  = exec;
  assign bus1.clear_pulso = clr;
  assign bus1.sel_op      = op;
  assign bus1.data_in     = din;

  rpn_stack_core #(.WIDTH(8),  .DEPTH(4)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  rpn_stack_core #(.WIDTH(16), .DEPTH(8)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: plain array stack per instance, pending result with a 2-edge countdown.
  longint mstk [2][16];
  int     msz  [2];
  int     mcnt [2];
  int     mpn  [2];
  longint mpr  [2];
  bit     mpc  [2];
  bit     merr [2];
  bit     mc   [2];
  bit     mz   [2];
  bit     mrv  [2];

  function automatic void alu(input int w, input int o, input longint a, input longint b,
                              output longint r, output bit c);
    longint m;
    m = (64'sd1 <<< w) - 1;
    c = 1'b0;
    case (o)
      0: begin r = (a + b) & m; c = ((a + b) >> w) != 0; end
      1: begin r = (a - b) & m; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~b & m;
      6: begin r = (b << 1) & m; c = ((b >> (w - 1)) & 1) != 0; end
      default: begin r = b >> 1; c = (b & 1) != 0; end
    endcase
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      msz[i] = 0; mcnt[i] = 0; merr[i] = 0; mc[i] = 0; mz[i] = 0; mrv[i] = 0;
    end
  endtask

  task automatic mstep(input int i);
    int     w, d, need;
    longint m, a, b, r;
    bit     c;
    w = (i == 0) ? 8 : 16;
    d = (i == 0) ? 4 : 8;
    m = (64'sd1 <<< w) - 1;
    mrv[i] = 0;
    if (clr) begin
      msz[i] = 0; merr[i] = 0; mcnt[i] = 0;
    end else if (mcnt[i] > 0) begin
      if (mcnt[i] == 2) begin
        msz[i] = msz[i] - mpn[i];
        mstk[i][msz[i]] = mpr[i];
        msz[i]++;
        mc[i]  = mpc[i];
        mz[i]  = (mpr[i] == 0);
        mrv[i] = 1;
      end
      mcnt[i]--;
    end else if (merr[i]) begin
      // stuck until clear
    end else if (enter) begin
      if (msz[i] == d) merr[i] = 1;
      else begin
        mstk[i][msz[i]] = longint'(din) & m;
        msz[i]++;
      end
    end else if (exec) begin
      need = (op >= 5) ? 1 : 2;
      if (msz[i] < need) merr[i] = 1;
      else begin
        b = mstk[i][msz[i] - 1];
        a = (need == 2) ? mstk[i][msz[i] - 2] : 0;
        alu(w, int'(op), a, b, r, c);
        mpr[i] = r; mpc[i] = c; mpn[i] = need; mcnt[i] = 2;
      end
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) mreset();
      else for (int i = 0; i < 2; i++) mstep(i);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input longint t, input longint dp, input bit bz,
                          input bit rv, input bit c, input bit z, input bit e);
    longint et;
    et = (msz[i] == 0) ? 0 : mstk[i][msz[i] - 1];
    chk($sformatf("i%0d tos", i),          t,  et);
    chk($sformatf("i%0d depth", i),        dp, longint'(msz[i]));
    chk($sformatf("i%0d busy", i),         longint'(bz), longint'(mcnt[i] > 0));
    chk($sformatf("i%0d result_valid", i), longint'(rv), longint'(mrv[i]));
    chk($sformatf("i%0d carry", i),        longint'(c),  longint'(mc[i]));
    chk($sformatf("i%0d zero", i),         longint'(z),  longint'(mz[i]));
    chk($sformatf("i%0d error", i),        longint'(e),  longint'(merr[i]));
  endtask

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      cmp_inst(0, longint'(bus0.tos), longint'(bus0.depth), bus0.busy, bus0.result_valid,
               bus0.carry, bus0.zero, bus0.error);
      cmp_inst(1, longint'(bus1.tos), longint'(bus1.depth), bus1.busy, bus1.result_valid,
               bus1.carry, bus1.zero, bus1.error);
    end
  end

  task automatic cyc(input bit e, input bit x, input bit c, input logic [2:0] o,
                     input logic [15:0] d);
    enter = e; exec = x; clr = c; op = o; din = d;
    @(posedge clk); #1;
    enter = 0; exec = 0; clr = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 3'd0, 16'h0);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, " tos0"}, longint'(bus0.tos), 0);
    chk({tag, " depth0"}, longint'(bus0.depth), 0);
    chk({tag, " busy0"}, longint'(bus0.busy), 0);
    chk({tag, " rv0"}, longint'(bus0.result_valid), 0);
    chk({tag, " err0"}, longint'(bus0.error), 0);
    chk({tag, " carry0"}, longint'(bus0.carry), 0);
    chk({tag, " depth1"}, longint'(bus1.depth), 0);
    chk({tag, " tos1"}, longint'(bus1.tos), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; enter = 0; exec = 0; clr = 0; op = 0; din = 0;
    repeat (2) @(posedge clk);
    #1 zero_outs("reset");
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;

    // 5 + 3 on both widths; result appears two cycles after the exec pulse
    cyc(1, 0, 0, 3'd0, 16'h05);
    cyc(1, 0, 0, 3'd0, 16'h03);
    cyc(0, 1, 0, 3'd0, 16'h0);
    chk("t1 busy0", longint'(bus0.busy), 1);
    chk("t1 rv0 early", longint'(bus0.result_valid), 0);
    idle();
    chk("t1 rv0", longint'(bus0.result_valid), 1);
    chk("t1 tos0", longint'(bus0.tos), 8);
    chk("t1 depth0", longint'(bus0.depth), 1);
    chk("t1 carry0", longint'(bus0.carry), 0);
    chk("t1 tos1", longint'(bus1.tos), 8);
    idle();
    chk("t1 busy0 after", longint'(bus0.busy), 0);

    // carry out of the top bit, then SUB to zero (8-bit) / 0x100 (16-bit)
    cyc(1, 0, 0, 3'd0, 16'hF0);
    cyc(1, 0, 0, 3'd0, 16'h20);
    cyc(0, 1, 0, 3'd0, 16'h0);
    idle();
    chk("t2 tos0", longint'(bus0.tos), 'h10);
    chk("t2 carry0", longint'(bus0.carry), 1);
    chk("t2 tos1", longint'(bus1.tos), 'h110);
    chk("t2 carry1", longint'(bus1.carry), 0);
    idle();
    cyc(1, 0, 0, 3'd0, 16'h10);
    cyc(0, 1, 0, 3'd1, 16'h0);
    idle();
    chk("t2 sub tos0", longint'(bus0.tos), 0);
    chk("t2 sub zero0", longint'(bus0.zero), 1);
    chk("t2 sub carry0", longint'(bus0.carry), 0);
    chk("t2 sub tos1", longint'(bus1.tos), 'h100);
    chk("t2 sub zero1", longint'(bus1.zero), 0);
    idle();

    // overflow on the fifth push for DEPTH=4 only
    cyc(0, 0, 1, 3'd0, 16'h0);
    for (int k = 1; k <= 5; k++) cyc(1, 0, 0, 3'd0, 16'(k));
    chk("t3 err0", longint'(bus0.error), 1);
    chk("t3 depth0", longint'(bus0.depth), 4);
    chk("t3 tos0", longint'(bus0.tos), 4);
    chk("t3 err1", longint'(bus1.error), 0);
    chk("t3 depth1", longint'(bus1.depth), 5);
    cyc(1, 0, 0, 3'd0, 16'h9);
    cyc(0, 1, 0, 3'd0, 16'h0);
    idle();
    chk("t3 ignored depth0", longint'(bus0.depth), 4);
    chk("t3 ignored rv0", longint'(bus0.result_valid), 0);
    idle();
    cyc(0, 0, 1, 3'd0, 16'h0);
    chk("t3 clr depth0", longint'(bus0.depth), 0);
    chk("t3 clr err0", longint'(bus0.error), 0);
    for (int k = 1; k <= 9; k++) cyc(1, 0, 0, 3'd0, 16'(k + 16'h100));
    chk("t3 err1 9th", longint'(bus1.error), 1);
    chk("t3 depth1 full", longint'(bus1.depth), 8);
    chk("t3 tos1 full", longint'(bus1.tos), 'h108);
    cyc(0, 0, 1, 3'd0, 16'h0);

    // binary op with one entry underflows; NOT on 0x01
    cyc(1, 0, 0, 3'd0, 16'h01);
    cyc(0, 1, 0, 3'd4, 16'h0);
    chk("t4 err0", longint'(bus0.error), 1);
    chk("t4 depth0", longint'(bus0.depth), 1);
    chk("t4 err1", longint'(bus1.error), 1);
    idle();
    chk("t4 rv0", longint'(bus0.result_valid), 0);
    cyc(0, 0, 1, 3'd0, 16'h0);
    cyc(1, 0, 0, 3'd0, 16'h01);
    cyc(0, 1, 0, 3'd5, 16'h0);
    idle();
    chk("t4 not tos0", longint'(bus0.tos), 'hFE);
    chk("t4 not tos1", longint'(bus1.tos), 'hFFFE);
    idle();

    // enter+exec together pushes only; exec while busy is dropped
    cyc(0, 0, 1, 3'd0, 16'h0);
    cyc(1, 0, 0, 3'd0, 16'h07);
    cyc(1, 0, 0, 3'd0, 16'h03);
    cyc(1, 1, 0, 3'd0, 16'h09);
    chk("t5 depth0", longint'(bus0.depth), 3);
    chk("t5 busy0", longint'(bus0.busy), 0);
    idle();
    chk("t5 rv0", longint'(bus0.result_valid), 0);
    cyc(0, 1, 0, 3'd2, 16'h0);
    cyc(0, 1, 0, 3'd2, 16'h0);
    chk("t5 and tos0", longint'(bus0.tos), 1);
    idle();
    chk("t5 depth0 after", longint'(bus0.depth), 2);
    chk("t5 busy0 after", longint'(bus0.busy), 0);

    // async reset in EXEC, then clear in EXEC
    cyc(0, 1, 0, 3'd0, 16'h0);
    #2 reset_n = 0;
    #1 zero_outs("t6 async");
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    cyc(1, 0, 0, 3'd0, 16'h04);
    cyc(1, 0, 0, 3'd0, 16'h06);
    cyc(0, 1, 0, 3'd0, 16'h0);
    cyc(0, 0, 1, 3'd0, 16'h0);
    chk("t6 clr depth0", longint'(bus0.depth), 0);
    chk("t6 clr rv0", longint'(bus0.result_valid), 0);
    chk("t6 clr busy0", longint'(bus0.busy), 0);
    idle();
    chk("t6 clr rv0 late", longint'(bus0.result_valid), 0);

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(99) < 35, $urandom_range(99) < 35, $urandom_range(99) < 4,
          3'($urandom_range(7)), 16'($urandom));
    end
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
